ahb_slave_rr_arbiter: RTL and testbench
=======================================

// Module: ahb_slave_rr_arbiter
// PURPOSE
//  Per-slave AHB arbiter, parametrised successor to the fixed 3-master slave arbiters.
//  - Arbitrates NUM_MASTERS requesters with true round-robin.
//  - Holds the grant for a whole burst, with a per-master hburst and a beat counter.
//  - Terminates undefined-length INCR bursts on request drop or a beat quota.
//  - Sits between the master-side request decode and the slave mux-select of one slave port.
// PARAMETERS
//  NUM_MASTERS     3    number of requesting masters (2..16)
//  MASTER_IDX_W    $clog2(NUM_MASTERS)  width of hmaster
//  INCR_MAX_BEATS  16   beat quota for INCR (undefined length) before forced re-arbitration (1..32)
// PORTS
//  hclk       in   1                 AHB clock, all state on rising edge
//  hreset_n   in   1                 asynchronous active-low reset
//  hreq       in   NUM_MASTERS       per-master request to this slave
//  hburst     in   NUM_MASTERS x burst_type  per-master burst type (AHB_package::burst_type)
//  hwait      in   1                 slave wait, 1 = current beat not accepted
//  hgrant     out  NUM_MASTERS       one-hot grant, gated: grant_q & ~hwait
//  hsel       out  1                 slave select = |grant_q
//  hmaster    out  MASTER_IDX_W      index of granted master (0 when none)
//  hlast      out  1                 current beat is last of the granted transaction
//  hmastlock  in   NUM_MASTERS       (only with AHB_ARB_LOCK_EN) per-master locked-transfer flag
// BEHAVIOUR
//  - Reset values (async on hreset_n low):
//    grant_q=0, ptr=0, beat=0, state=ARB_IDLE, burst_q=SINGLE, hsel=0, hgrant=0, hmaster=0, hlast=0.
//  - Beat accepted when hsel & ~hwait.
//  - Pick: rotating-priority search of hreq starting at index ptr, wrapping at NUM_MASTERS-1 -> 0.
//  - ARB_IDLE:
//    - grant_q <= pick.
//    - If pick != 0: burst_q <= hburst[winner], beat <= 0, -> ARB_BURST.
//    - Latency is one cycle: hreq rises at edge k, grant_q is valid after edge k+1.
//  - ARB_BURST:
//    - beat increments by 1 per accepted beat; it holds while hwait=1.
//    - limit: SINGLE=0; INCR4/WRAP4=3; INCR8/WRAP8=7; INCR16/WRAP16=15; INCR=INCR_MAX_BEATS-1.
//    - hlast = (beat==limit) or (burst_q==INCR and hreq[granted]==0).
//    - Fixed-length bursts run to completion; a hreq drop mid-burst is ignored.
//    - On accepted beat with hlast=1: ptr <= granted index + 1 (mod NUM_MASTERS).
//      Re-pick happens in the same edge (back-to-back grant, no idle cycle); if no request -> ARB_IDLE with grant_q=0.
//    - The just-finished master is lowest priority in that pick.
//  - hlast with hwait=1: nothing changes until hwait falls.
//  - Single requester: re-granted each transaction, no bubble.
//  - Beat counter is 5 bits; it never wraps because limit <= 31.
//  - Reset mid-burst: grant drops immediately (async), arbitration restarts from master 0.
// CONFIGURATION
//  - AHB_ARB_LOCK_EN defined:
//    - hmastlock port present.
//    - If hmastlock[granted]=1 at the accepted hlast beat, grant_q is kept and ptr is not advanced; the beat count restarts.
//    - Lock is released at the first hlast beat with hmastlock=0.
//  - AHB_ARB_LOCK_EN undefined: hmastlock port absent; pure round-robin.
// STRUCTURE
//  - AHB_package additions:
//    - arb_state_e {ARB_IDLE, ARB_BURST}
//    - function burst_limit(burst_type, int incr_max) returning logic[4:0]
//    - localparam ARB_BEAT_W=5
//  - Sub-module ahb_rr_pick:
//    - Purely combinational rotating priority encoder.
//    - Inputs req[N], ptr; outputs onehot[N], idx, valid.
//  - Top holds the FSM, the beat counter, ptr and the grant registers.
// TESTING
//  1. Reset, hreq=3'b111, all SINGLE, hwait=0 -> grants M0,M1,M2,M0 on consecutive cycles; hlast=1 every beat.
//  2. M1 INCR8, hreq=3'b011, hwait=0 ->
//     M1 held 8 accepted beats with hlast on beat 7, then M0 granted next cycle; M1 dropping hreq at beat 3 is ignored.
//  3. M2 INCR4 with hwait=1 on beats 1 and 2 ->
//     beat holds, hgrant=0 and hsel=1 during waits; 6 cycles total; hlast asserts only on the accepted 4th beat.
//  4. M0 INCR, INCR_MAX_BEATS=16, hreq[0] held ->
//     forced hlast at beat 15, M1 (requesting) gets the grant; repeat with hreq[0] dropped at beat 5 -> hlast at beat 5.
//  5. hreset_n pulsed low mid-burst (beat 2 of WRAP8) ->
//     hgrant/hsel/hlast go 0 asynchronously; after release with hreq=3'b110, M1 is granted first.
//  6. AHB_ARB_LOCK_EN: M1 SINGLE with hmastlock=1 for 3 transfers, M0 and M2 requesting ->
//     M1 granted 3 cycles, then M2 (ptr=2).

Source files
------------

// File: rtl/ahb_slave_rr_arbiter_pkg.sv
// Shared types for the per-slave AHB round-robin arbiter: burst encodings,
// arbiter FSM states and the per-burst beat limit.
package ahb_slave_rr_arbiter_pkg;

    localparam int BURST_W    = 3;
    localparam int ARB_BEAT_W = 5;

    typedef enum logic [BURST_W-1:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } burst_type;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    // Index of the final beat of a burst; INCR is capped by the quota.
    function automatic logic [ARB_BEAT_W-1:0] burst_limit(input burst_type b, input int incr_max);
        logic [ARB_BEAT_W-1:0] lim;
        case (b)
            SINGLE:         lim = 5'd0;
            INCR4, WRAP4:   lim = 5'd3;
            INCR8, WRAP8:   lim = 5'd7;
            INCR16, WRAP16: lim = 5'd15;
            INCR:           lim = ARB_BEAT_W'(incr_max - 1);
            default:        lim = 5'd0;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/ahb_slave_rr_arbiter_pick.sv
// Combinational rotating-priority encoder: first set request at or after ptr,
// wrapping from N-1 back to 0.
module ahb_rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!valid && req[j]) begin
                valid     = 1'b1;
                onehot[j] = 1'b1;
                idx       = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/ahb_slave_rr_arbiter.sv
// Per-slave AHB arbiter: round-robin grant held for a whole burst, INCR bursts
// cut on request drop or beat quota. Optional locked transfers via AHB_ARB_LOCK_EN.
module ahb_slave_rr_arbiter
    import ahb_slave_rr_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 3,
    parameter int MASTER_IDX_W   = $clog2(NUM_MASTERS),
    parameter int INCR_MAX_BEATS = 16
) (
    input  logic                                  hclk,
    input  logic                                  hreset_n,
    input  logic [NUM_MASTERS-1:0]                hreq,
    input  logic [NUM_MASTERS-1:0][BURST_W-1:0]   hburst,
    input  logic                                  hwait,
`ifdef AHB_ARB_LOCK_EN
    input  logic [NUM_MASTERS-1:0]                hmastlock,
`endif
    output logic [NUM_MASTERS-1:0]                hgrant,
    output logic                                  hsel,
    output logic [MASTER_IDX_W-1:0]               hmaster,
    output logic                                  hlast
);

    arb_state_e                r_state;
    logic [NUM_MASTERS-1:0]    r_grant;
    logic [MASTER_IDX_W-1:0]   r_idx;
    logic [MASTER_IDX_W-1:0]   r_ptr;
    logic [ARB_BEAT_W-1:0]     r_beat;
    burst_type                 r_burst;

    logic [NUM_MASTERS-1:0]    w_pick_onehot;
    logic [MASTER_IDX_W-1:0]   w_pick_idx;
    logic                      w_pick_valid;
    logic [MASTER_IDX_W-1:0]   w_pick_ptr;
    logic [MASTER_IDX_W-1:0]   w_next_ptr;
    logic [ARB_BEAT_W-1:0]     w_limit;
    logic                      w_accept;
    logic                      w_last;
    logic                      w_lock_hold;

`ifdef AHB_ARB_LOCK_EN
    assign w_lock_hold = hmastlock[r_idx];
`else
    assign w_lock_hold = 1'b0;
`endif

    assign w_limit    = burst_limit(r_burst, INCR_MAX_BEATS);
    assign w_next_ptr = (r_idx == MASTER_IDX_W'(NUM_MASTERS - 1)) ? '0 : r_idx + 1'b1;
    // On a burst end the finishing master must be lowest priority in the re-pick.
    assign w_pick_ptr = (r_state == ARB_BURST) ? w_next_ptr : r_ptr;

    assign hsel     = |r_grant;
    assign hgrant   = r_grant & ~{NUM_MASTERS{hwait}};
    assign hmaster  = r_idx;
    assign w_accept = hsel & ~hwait;
    assign w_last   = (r_state == ARB_BURST) &&
                      ((r_beat == w_limit) || ((r_burst == INCR) && !hreq[r_idx]));
    assign hlast    = w_last;

    ahb_rr_pick #(
        .N     (NUM_MASTERS),
        .IDX_W (MASTER_IDX_W)
    ) u_pick (
        .req    (hreq),
        .ptr    (w_pick_ptr),
        .onehot (w_pick_onehot),
        .idx    (w_pick_idx),
        .valid  (w_pick_valid)
    );

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_beat  <= '0;
            r_burst <= SINGLE;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    r_grant <= w_pick_onehot;
                    if (w_pick_valid) begin
                        r_idx   <= w_pick_idx;
                        r_burst <= burst_type'(hburst[w_pick_idx]);
                        r_beat  <= '0;
                        r_state <= ARB_BURST;
                    end
                end
                ARB_BURST: begin
                    if (w_accept) begin
                        if (!w_last) begin
                            r_beat <= r_beat + 5'd1;
                        end else if (w_lock_hold) begin
                            // Locked master keeps the bus; start its next transfer.
                            r_beat  <= '0;
                            r_burst <= burst_type'(hburst[r_idx]);
                        end else begin
                            r_ptr   <= w_next_ptr;
                            r_grant <= w_pick_onehot;
                            r_beat  <= '0;
                            if (w_pick_valid) begin
                                r_idx   <= w_pick_idx;
                                r_burst <= burst_type'(hburst[w_pick_idx]);
                            end else begin
                                r_idx   <= '0;
                                r_state <= ARB_IDLE;
                            end
                        end
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_slave_rr_arbiter.sv
// Table-driven bench for ahb_slave_rr_arbiter with a per-cycle expectation queue,
// plus a hand-written asynchronous reset sequence.
module tb_ahb_slave_rr_arbiter;
    import ahb_slave_rr_arbiter_pkg::*;

    localparam int NM = 3;
    localparam int IW = 2;

    logic                 hclk = 1'b0;
    logic                 hreset_n;
    logic [NM-1:0]        hreq;
    logic [NM-1:0][2:0]   hburst;
    logic                 hwait;
`ifdef AHB_ARB_LOCK_EN
    logic [NM-1:0]        hmastlock;
`endif
    logic [NM-1:0]        hgrant;
    logic                 hsel;
    logic [IW-1:0]        hmaster;
    logic                 hlast;

    typedef struct {
        logic [2:0]      req;
        logic [2:0][2:0] burst;
        logic            w;
        logic [2:0]      lock;
        logic [2:0]      eg;
        logic            es;
        logic [1:0]      em;
        logic            el;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   vnum  = 0;

    ahb_slave_rr_arbiter #(
        .NUM_MASTERS    (NM),
        .MASTER_IDX_W   (IW),
        .INCR_MAX_BEATS (16)
    ) dut (
        .hclk      (hclk),
        .hreset_n  (hreset_n),
        .hreq      (hreq),
        .hburst    (hburst),
        .hwait     (hwait),
`ifdef AHB_ARB_LOCK_EN
        .hmastlock (hmastlock),
`endif
        .hgrant    (hgrant),
        .hsel      (hsel),
        .hmaster   (hmaster),
        .hlast     (hlast)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // es/em/el describe the expected slave-side view; grant is derived from them.
    function automatic void add(input logic [2:0] req, input burst_type b0, input burst_type b1,
                                input burst_type b2, input logic w, input logic es,
                                input logic [1:0] em, input logic el,
                                input logic [2:0] lk = 3'b000);
        vec_t v;
        v.req      = req;
        v.burst[0] = b0;
        v.burst[1] = b1;
        v.burst[2] = b2;
        v.w        = w;
        v.lock     = lk;
        v.es       = es;
        v.em       = em;
        v.el       = el;
        v.eg       = (es && !w) ? (3'b001 << em) : 3'b000;
        vecs.push_back(v);
    endfunction

    task automatic run_vec(input vec_t v);
        vec_t e;
        @(posedge hclk);
        #1;
        hreq   = v.req;
        hburst = v.burst;
        hwait  = v.w;
`ifdef AHB_ARB_LOCK_EN
        hmastlock = v.lock;
`endif
        sb.push_back(v);
        @(negedge hclk);
        e = sb.pop_front();
        chk($sformatf("v%0d hgrant", vnum), 32'(hgrant), 32'(e.eg));
        chk($sformatf("v%0d hsel", vnum), 32'(hsel), 32'(e.es));
        chk($sformatf("v%0d hmaster", vnum), 32'(hmaster), 32'(e.em));
        chk($sformatf("v%0d hlast", vnum), 32'(hlast), 32'(e.el));
        vnum++;
    endtask

    task automatic run_all();
        while (vecs.size() != 0) run_vec(vecs.pop_front());
    endtask

    initial begin
        hreset_n = 1'b0;
        hreq     = '0;
        hburst   = '0;
        hwait    = 1'b0;
`ifdef AHB_ARB_LOCK_EN
        hmastlock = '0;
`endif

        // Round robin of single transfers, then drain to idle (ptr ends at 1)
        add(3'b111, SINGLE, SINGLE, SINGLE, 0, 0, 0, 0);
        add(3'b111, SINGLE, SINGLE, SINGLE, 0, 1, 0, 1);
        add(3'b111, SINGLE, SINGLE, SINGLE, 0, 1, 1, 1);
        add(3'b111, SINGLE, SINGLE, SINGLE, 0, 1, 2, 1);
        add(3'b000, SINGLE, SINGLE, SINGLE, 0, 1, 0, 1);
        add(3'b000, SINGLE, SINGLE, SINGLE, 0, 0, 0, 0);
        // M1 INCR8 runs 8 beats despite dropping hreq at beat 3; M0 follows, no bubble
        add(3'b011, SINGLE, INCR8, SINGLE, 0, 0, 0, 0);
        for (int b = 0; b < 8; b++)
            add((b < 3) ? 3'b011 : 3'b001, SINGLE, INCR8, SINGLE, 0, 1, 1, (b == 7));
        add(3'b001, SINGLE, INCR8, SINGLE, 0, 1, 0, 1);
        add(3'b000, SINGLE, INCR8, SINGLE, 0, 1, 0, 1);
        add(3'b000, SINGLE, INCR8, SINGLE, 0, 0, 0, 0);
        // M2 INCR4 with two wait states: 6 granted cycles
        add(3'b100, SINGLE, SINGLE, INCR4, 0, 0, 0, 0);
        add(3'b100, SINGLE, SINGLE, INCR4, 0, 1, 2, 0);
        add(3'b100, SINGLE, SINGLE, INCR4, 1, 1, 2, 0);
        add(3'b100, SINGLE, SINGLE, INCR4, 1, 1, 2, 0);
        add(3'b100, SINGLE, SINGLE, INCR4, 0, 1, 2, 0);
        add(3'b100, SINGLE, SINGLE, INCR4, 0, 1, 2, 0);
        add(3'b000, SINGLE, SINGLE, INCR4, 0, 1, 2, 1);
        add(3'b000, SINGLE, SINGLE, INCR4, 0, 0, 0, 0);
        // M0 INCR hits the 16-beat quota (last beat stalled once), M1 takes over
        add(3'b011, INCR, SINGLE, SINGLE, 0, 0, 0, 0);
        for (int b = 0; b < 15; b++)
            add(3'b011, INCR, SINGLE, SINGLE, 0, 1, 0, 0);
        add(3'b011, INCR, SINGLE, SINGLE, 1, 1, 0, 1);
        add(3'b011, INCR, SINGLE, SINGLE, 0, 1, 0, 1);
        add(3'b001, INCR, SINGLE, SINGLE, 0, 1, 1, 1);
        // M0 INCR again, request dropped at beat 5 ends it there
        for (int b = 0; b < 5; b++)
            add(3'b001, INCR, SINGLE, SINGLE, 0, 1, 0, 0);
        add(3'b000, INCR, SINGLE, SINGLE, 0, 1, 0, 1);
        add(3'b000, INCR, SINGLE, SINGLE, 0, 0, 0, 0);

        #2;
        chk("rst hgrant", 32'(hgrant), 32'h0);
        chk("rst hsel", 32'(hsel), 32'h0);
        chk("rst hmaster", 32'(hmaster), 32'h0);
        chk("rst hlast", 32'(hlast), 32'h0);
        #10 hreset_n = 1'b1;
        run_all();

        // Reset pulsed at beat 2 of an M0 WRAP8 burst
        add(3'b001, WRAP8, SINGLE, SINGLE, 0, 0, 0, 0);
        for (int b = 0; b < 3; b++)
            add(3'b001, WRAP8, SINGLE, SINGLE, 0, 1, 0, 0);
        run_all();
        #1 hreset_n = 1'b0;
        #1;
        chk("async hgrant", 32'(hgrant), 32'h0);
        chk("async hsel", 32'(hsel), 32'h0);
        chk("async hmaster", 32'(hmaster), 32'h0);
        chk("async hlast", 32'(hlast), 32'h0);
        hreq   = 3'b110;
        hburst = '0;
        @(posedge hclk);
        chk("held hsel", 32'(hsel), 32'h0);
        #3 hreset_n = 1'b1;
        add(3'b110, SINGLE, SINGLE, SINGLE, 0, 1, 1, 1);
        add(3'b000, SINGLE, SINGLE, SINGLE, 0, 1, 2, 1);
        add(3'b000, SINGLE, SINGLE, SINGLE, 0, 0, 0, 0);
        run_all();

`ifdef AHB_ARB_LOCK_EN
        // M1 locked for 3 single transfers while M0/M2 wait; M2 next (ptr=2)
        add(3'b010, SINGLE, SINGLE, SINGLE, 0, 0, 0, 0, 3'b010);
        add(3'b111, SINGLE, SINGLE, SINGLE, 0, 1, 1, 1, 3'b010);
        add(3'b111, SINGLE, SINGLE, SINGLE, 0, 1, 1, 1, 3'b010);
        add(3'b111, SINGLE, SINGLE, SINGLE, 0, 1, 1, 1, 3'b000);
        add(3'b000, SINGLE, SINGLE, SINGLE, 0, 1, 2, 1, 3'b000);
        add(3'b000, SINGLE, SINGLE, SINGLE, 0, 0, 0, 0, 3'b000);
        run_all();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
